// File: rtl/program_counter_pkg.sv
// Shared CPU definitions: address/word widths, reset vector and the address type
// used by the PC, instruction memory and the control unit.
package program_counter_pkg;

    localparam int ADDR_W = 14;
    localparam int WORD_W = 19;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t RESET_VEC = 14'h0000;

    // Next sequential address, wrapping modulo 2^ADDR_W.
    function automatic addr_t addr_inc(input addr_t a);
        return a + addr_t'(1'b1);
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: holds the address of the executing instruction and drives it
// to the fetch path. Per-edge priority is reset, load, increment, then hold.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int                 ADDR_W    = program_counter_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_VEC = program_counter_pkg::RESET_VEC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadPC,
    input  logic              incPC,
    input  logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] execadd
);

    // The initialiser keeps the fetch address defined before the first reset.
    logic [ADDR_W-1:0] pc_r = RESET_VEC;

    // PC update: reset overrides load, load overrides increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_VEC;
        end else if (loadPC) begin
            pc_r <= address;
        end else if (incPC) begin
            pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    assign execadd = pc_r;

endmodule

// File: tb/tb_program_counter.sv
// Directed, table-driven bench for program_counter.
module tb_program_counter;

    localparam int AW = 14;

    logic          clk;
    logic          rst;
    logic          loadPC;
    logic          incPC;
    logic [AW-1:0] address;
    logic [AW-1:0] execadd;

    int checks;
    int failures;

    program_counter dut (
        .clk     (clk),
        .rst     (rst),
        .loadPC  (loadPC),
        .incPC   (incPC),
        .address (address),
        .execadd (execadd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          r;
        logic          ld;
        logic          inc;
        logic [AW-1:0] addr;
        logic [AW-1:0] exp;
        string         name;
    } vec_t;

    vec_t vecs[$];

    // Control inputs must never be X/Z at a sampling edge.
    always @(posedge clk) begin
        if ($isunknown({rst, loadPC, incPC})) begin
            failures = failures + 1;
            $display("FAIL ctrl_x: rst/loadPC/incPC = %b%b%b, required known values", rst, loadPC, incPC);
        end
    end

    task automatic check(input string name, input logic [AW-1:0] exp);
        checks = checks + 1;
        if ($isunknown(execadd) || execadd !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: execadd = %h, required %h", name, execadd, exp);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic inc, input logic [AW-1:0] a);
        @(negedge clk);
        rst     = r;
        loadPC  = ld;
        incPC   = inc;
        address = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] model;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        loadPC   = 1'b0;
        incPC    = 1'b0;
        address  = 14'h0000;

        // Power-up value is visible before any edge as well.
        #1;
        check("powerup_t0", 14'h0000);

        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h1555, 14'h0000, "powerup_1"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h2AAA, 14'h0000, "powerup_2"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 14'h0000, "reset"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, "hold_1"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, "hold_2"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000, "hold_3"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 14'h0123, 14'h0123, "load"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h3ABC, 14'h0123, "addr_ignored_1"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0001, 14'h0123, "addr_ignored_2"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0777, 14'h0124, "inc_1"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0777, 14'h0125, "inc_2"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0777, 14'h0126, "inc_3"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0777, 14'h0127, "inc_4"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 14'h3FFF, 14'h3FFF, "load_over_inc"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0000, 14'h0000, "wrap"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 14'h1111, 14'h1111, "load_held_1"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 14'h2222, 14'h2222, "load_held_2"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 14'h0010, 14'h0010, "load_0010"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0000, 14'h0011, "midrst_inc_1"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0000, 14'h0012, "midrst_inc_2"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 14'h2AAA, 14'h0000, "midrst_reset"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h2AAA, 14'h0001, "post_rst_1"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h2AAA, 14'h0002, "post_rst_2"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 14'h0000, 14'h0000, "reset_again"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 14'h3FF0, 14'h3FF0, "load_3ff0"});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].ld, vecs[i].inc, vecs[i].addr);
            check(vecs[i].name, vecs[i].exp);
        end

        // Long increment run across the wrap boundary against a modulo model.
        model = 14'h3FF0;
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 1'b0, 1'b1, 14'(k * 14'h0155));
            model = model + 14'h0001;
            check("inc_run", model);
        end

        // Reset held for several edges while load and increment stay asserted.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1, 14'h1234);
            check("rst_held", 14'h0000);
        end
        step(1'b0, 1'b1, 1'b1, 14'h1234);
        check("first_cmd_after_rst", 14'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
